// File: rtl/peripheral_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_timer_bank
// Purpose  : Bus-mapped bank of N prescaled reload timers plus LED, switch and
//            digit registers, with a combined maskable interrupt output.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_timer_bank #(
  parameter int N_TIMERS = 2,
  parameter int LED_W    = 8,
  parameter int SW_W     = 8,
  parameter int DIGI_W   = 12,
  parameter int PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  input  logic [SW_W-1:0]     switch,
  output logic [31:0]         rdata,
  output logic [LED_W-1:0]    led,
  output logic [DIGI_W-1:0]   digi,
  output logic [N_TIMERS-1:0] irq_vec,
  output logic                IRQ
);

  localparam logic [31:0] c_addr_led  = 32'h4000_000C;
  localparam logic [31:0] c_addr_sw   = 32'h4000_0010;
  localparam logic [31:0] c_addr_digi = 32'h4000_0014;
  localparam logic [31:0] c_addr_stat = 32'h4000_0020;
  localparam logic [1:0]  c_reg_th    = 2'd0;
  localparam logic [1:0]  c_reg_tl    = 2'd1;
  localparam logic [1:0]  c_reg_tcon  = 2'd2;
  localparam logic [1:0]  c_reg_presc = 2'd3;

  logic [LED_W-1:0]    r_led;
  logic [DIGI_W-1:0]   r_digi;
  logic [31:0]         r_th    [N_TIMERS];
  logic [31:0]         r_tl    [N_TIMERS];
  logic [PRESC_W-1:0]  r_presc [N_TIMERS];
  logic [PRESC_W-1:0]  r_pcnt  [N_TIMERS];
  logic [N_TIMERS-1:0] r_en;
  logic [N_TIMERS-1:0] r_ie;
  logic [N_TIMERS-1:0] r_os;
  logic [N_TIMERS-1:0] r_pend;

  logic                w_ch_area;
  logic                w_wr_led;
  logic                w_wr_digi;
  logic                w_wr_stat;
  logic [N_TIMERS-1:0] w_ch_sel;
  logic [N_TIMERS-1:0] w_wr_th;
  logic [N_TIMERS-1:0] w_wr_tl;
  logic [N_TIMERS-1:0] w_wr_tcon;
  logic [N_TIMERS-1:0] w_wr_presc;
  logic [N_TIMERS-1:0] w_tick;
  logic [N_TIMERS-1:0] w_ovf;

  // Channel window 0x4000_01x0..0x4000_01xC, word aligned only.
  assign w_ch_area = (addr[31:8] == 24'h40_0001) && (addr[1:0] == 2'b00);
  assign w_wr_led  = wr && (addr == c_addr_led);
  assign w_wr_digi = wr && (addr == c_addr_digi);
  assign w_wr_stat = wr && (addr == c_addr_stat);

  always_comb begin
    w_ch_sel   = '0;
    w_wr_th    = '0;
    w_wr_tl    = '0;
    w_wr_tcon  = '0;
    w_wr_presc = '0;
    w_tick     = '0;
    w_ovf      = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      w_ch_sel[i]   = w_ch_area && (addr[7:4] == 4'(i));
      w_wr_th[i]    = wr && w_ch_sel[i] && (addr[3:2] == c_reg_th);
      w_wr_tl[i]    = wr && w_ch_sel[i] && (addr[3:2] == c_reg_tl);
      w_wr_tcon[i]  = wr && w_ch_sel[i] && (addr[3:2] == c_reg_tcon);
      w_wr_presc[i] = wr && w_ch_sel[i] && (addr[3:2] == c_reg_presc);
      w_tick[i]     = r_en[i] && (r_pcnt[i] == r_presc[i]);
      w_ovf[i]      = w_tick[i] && (r_tl[i] == 32'hFFFF_FFFF);
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (addr == c_addr_led)       rdata = 32'(r_led);
      else if (addr == c_addr_sw)   rdata = 32'(switch);
      else if (addr == c_addr_digi) rdata = 32'(r_digi);
      else if (addr == c_addr_stat) rdata = 32'(r_pend);
      for (int i = 0; i < N_TIMERS; i++) begin
        if (w_ch_sel[i]) begin
          case (addr[3:2])
            c_reg_th:    rdata = r_th[i];
            c_reg_tl:    rdata = r_tl[i];
            c_reg_tcon:  rdata = {29'd0, r_os[i], r_ie[i], r_en[i]};
            c_reg_presc: rdata = 32'(r_presc[i]);
            default:     rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led  <= '0;
      r_digi <= '0;
      r_en   <= '0;
      r_ie   <= '0;
      r_os   <= '0;
      r_pend <= '0;
      for (int i = 0; i < N_TIMERS; i++) begin
        r_th[i]    <= '0;
        r_tl[i]    <= '0;
        r_presc[i] <= '0;
        r_pcnt[i]  <= '0;
      end
    end else begin
      if (w_wr_led)  r_led  <= wdata[LED_W-1:0];
      if (w_wr_digi) r_digi <= wdata[DIGI_W-1:0];
      for (int i = 0; i < N_TIMERS; i++) begin
        if (w_wr_th[i])    r_th[i]    <= wdata;
        if (w_wr_presc[i]) r_presc[i] <= wdata[PRESC_W-1:0];

        if (w_wr_tcon[i] || w_wr_presc[i] || !r_en[i] || w_tick[i])
          r_pcnt[i] <= '0;
        else
          r_pcnt[i] <= r_pcnt[i] + PRESC_W'(1);

        // Bus writes take priority over the timer's own update.
        if (w_wr_tl[i])     r_tl[i] <= wdata;
        else if (w_ovf[i])  r_tl[i] <= r_th[i];
        else if (w_tick[i]) r_tl[i] <= r_tl[i] + 32'd1;

        if (w_wr_tcon[i]) begin
          r_en[i] <= wdata[0];
          r_ie[i] <= wdata[1];
          r_os[i] <= wdata[2];
        end else if (w_ovf[i] && r_os[i]) begin
          r_en[i] <= 1'b0;
        end

        // A new overflow beats a simultaneous W1C.
        if (w_ovf[i])                     r_pend[i] <= 1'b1;
        else if (w_wr_stat && wdata[i])   r_pend[i] <= 1'b0;
      end
    end
  end

  assign led     = r_led;
  assign digi    = r_digi;
  assign irq_vec = r_pend & r_ie;
  assign IRQ     = |irq_vec;

endmodule
`default_nettype wire

// File: tb/tb_peripheral_timer_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_peripheral_timer_bank
// Purpose  : Self-checking bench: register table, directed timer corner cases
//            and randomized bus traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_timer_bank;

  localparam int N_TIMERS = 2;
  localparam int LED_W    = 8;
  localparam int SW_W     = 8;
  localparam int DIGI_W   = 12;
  localparam int PRESC_W  = 16;

  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_STAT = 32'h4000_0020;
  localparam logic [31:0] A_TH0  = 32'h4000_0100;
  localparam logic [31:0] A_TL0  = 32'h4000_0104;
  localparam logic [31:0] A_TC0  = 32'h4000_0108;
  localparam logic [31:0] A_PR0  = 32'h4000_010C;
  localparam logic [31:0] A_TH1  = 32'h4000_0110;
  localparam logic [31:0] A_TL1  = 32'h4000_0114;
  localparam logic [31:0] A_TC1  = 32'h4000_0118;
  localparam logic [31:0] A_PR1  = 32'h4000_011C;

  logic                clk;
  logic                reset;
  logic                rd;
  logic                wr;
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic [SW_W-1:0]     switch;
  logic [31:0]         rdata;
  logic [LED_W-1:0]    led;
  logic [DIGI_W-1:0]   digi;
  logic [N_TIMERS-1:0] irq_vec;
  logic                IRQ;

  int n_chk;
  int n_fail;

  peripheral_timer_bank #(
    .N_TIMERS(N_TIMERS), .LED_W(LED_W), .SW_W(SW_W), .DIGI_W(DIGI_W), .PRESC_W(PRESC_W)
  ) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .switch(switch), .rdata(rdata), .led(led), .digi(digi),
    .irq_vec(irq_vec), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Behavioural model: each channel ticks once every (PRESC+1) enabled cycles.
  logic [31:0]  m_th      [N_TIMERS];
  logic [31:0]  m_tl      [N_TIMERS];
  logic [15:0]  m_presc   [N_TIMERS];
  int unsigned  m_elapsed [N_TIMERS];
  bit           m_en      [N_TIMERS];
  bit           m_ie      [N_TIMERS];
  bit           m_os      [N_TIMERS];
  bit           m_pend    [N_TIMERS];
  logic [7:0]   m_led;
  logic [11:0]  m_digi;

  task automatic mreset();
    m_led  = '0;
    m_digi = '0;
    for (int i = 0; i < N_TIMERS; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_presc[i] = '0; m_elapsed[i] = 0;
      m_en[i] = 0;  m_ie[i] = 0;  m_os[i] = 0;     m_pend[i] = 0;
    end
  endtask

  // Returns channel index and register offset, or -1 when not a channel register.
  function automatic int ch_of(input logic [31:0] a, output int off);
    int rel;
    off = 0;
    if (a < 32'h4000_0100 || a >= 32'h4000_0100 + 32'(16 * N_TIMERS)) return -1;
    rel = int'(a - 32'h4000_0100);
    off = rel % 16;
    if (off % 4 != 0) return -1;
    return rel / 16;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    int ch;
    int off;
    ch = ch_of(a, off);
    if (a == A_LED)  return {24'd0, m_led};
    if (a == A_SW)   return {24'd0, switch};
    if (a == A_DIGI) return {20'd0, m_digi};
    if (a == A_STAT) return {30'd0, m_pend[1], m_pend[0]};
    if (ch < 0) return 32'd0;
    case (off)
      0:       return m_th[ch];
      4:       return m_tl[ch];
      8:       return {29'd0, m_os[ch], m_ie[ch], m_en[ch]};
      default: return {16'd0, m_presc[ch]};
    endcase
  endfunction

  task automatic mstep(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit ovf [N_TIMERS];
    bit tk;
    int ch;
    int off;
    for (int i = 0; i < N_TIMERS; i++) begin
      tk = m_en[i] && (m_elapsed[i] == 32'(m_presc[i]));
      ovf[i] = tk && (m_tl[i] == 32'hFFFF_FFFF);
      m_elapsed[i] = (!m_en[i] || tk) ? 0 : m_elapsed[i] + 1;
      if (ovf[i]) begin
        m_tl[i] = m_th[i];
        m_pend[i] = 1;
        if (m_os[i]) m_en[i] = 0;
      end else if (tk) begin
        m_tl[i] = m_tl[i] + 32'd1;
      end
    end
    if (w) begin
      ch = ch_of(a, off);
      if (a == A_LED)  m_led  = d[7:0];
      if (a == A_DIGI) m_digi = d[11:0];
      if (a == A_STAT)
        for (int i = 0; i < N_TIMERS; i++) if (d[i] && !ovf[i]) m_pend[i] = 0;
      if (ch >= 0) begin
        case (off)
          0: m_th[ch] = d;
          4: m_tl[ch] = d;
          8: begin
            m_en[ch] = d[0]; m_ie[ch] = d[1]; m_os[ch] = d[2]; m_elapsed[ch] = 0;
          end
          default: begin
            m_presc[ch] = d[15:0]; m_elapsed[ch] = 0;
          end
        endcase
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) mreset();
    else        mstep(wr, addr, wdata);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    rd = 1'b1; addr = a; #1;
    chk(name, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic wreg(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 15);
    case (r)
      0:  return A_LED;
      1:  return A_SW;
      2:  return A_DIGI;
      3:  return A_STAT;
      12: return 32'h4000_0018;
      13: return 32'h4000_0120;
      14: return 32'h4000_0106;
      15: return 32'h4000_0024;
      default: return 32'h4000_0100 + 32'((r - 4) / 4) * 32'h10 + 32'((r - 4) % 4) * 32'd4;
    endcase
  endfunction

  // Biased so overflows happen often: TL/TH near the top, small prescalers.
  function automatic logic [31:0] pick_data(input logic [31:0] a);
    logic [31:0] v;
    v = $urandom;
    if (a[31:8] == 24'h40_0001) begin
      case (a[3:0])
        4'h0: if (v[0]) v = 32'hFFFF_FFF0 | {28'd0, v[7:4]};
        4'h4: if (v[1:0] != 2'b00) v = 32'hFFFF_FFFF - {29'd0, v[6:4]};
        4'hC: if (v[3:2] != 2'b00) v = {v[31:18], 16'd0, v[17:16]};
        default: ;
      endcase
    end
    return v;
  endfunction

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_vec;
    n_chk = 0; n_fail = 0;
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; switch = 8'h3C;
    mreset();

    tbl[0]  = '{A_LED,           32'h0000_00A5, A_LED,           32'h0000_00A5};
    tbl[1]  = '{A_DIGI,          32'h0000_FFFF, A_DIGI,          32'h0000_0FFF};
    tbl[2]  = '{A_SW,            32'h0000_0012, A_SW,            32'h0000_003C};
    tbl[3]  = '{32'h4000_0018,   32'hDEAD_BEEF, 32'h4000_0018,   32'h0000_0000};
    tbl[4]  = '{A_TH1,           32'h1234_5678, A_TH1,           32'h1234_5678};
    tbl[5]  = '{A_PR1,           32'hFFFF_ABCD, A_PR1,           32'h0000_ABCD};
    tbl[6]  = '{A_TC1,           32'hFFFF_FFFA, A_TC1,           32'h0000_0002};
    tbl[7]  = '{32'h4000_0120,   32'h0000_0099, 32'h4000_0120,   32'h0000_0000};
    tbl[8]  = '{32'h4000_0101,   32'h0000_0077, A_TH0,           32'h0000_0000};
    tbl[9]  = '{A_LED,           32'h0000_01FF, A_LED,           32'h0000_00FF};
    tbl[10] = '{A_TL0,           32'h0000_1234, A_TL0,           32'h0000_1234};
    tbl[11] = '{A_STAT,          32'h0000_0003, A_STAT,          32'h0000_0000};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick_n(1);
    peek("reset_tl0", A_TL0, 32'h0);
    peek("reset_tcon1", A_TC1, 32'h0);
    chk("reset_irq", {31'd0, IRQ}, 32'h0);

    for (int k = 0; k < 12; k++) begin
      wreg(tbl[k].waddr, tbl[k].wdata);
      peek($sformatf("tbl[%0d]", k), tbl[k].raddr, tbl[k].exp);
    end
    chk("led_port", {24'd0, led}, 32'hFF);
    chk("digi_port", {20'd0, digi}, 32'hFFF);

    rd = 1'b0; addr = A_LED; #1;
    chk("rd0_returns_zero", rdata, 32'h0);
    wr = 1'b1; rd = 1'b1; addr = A_LED; wdata = 32'h33; #1;
    chk("rd_wr_prewrite", rdata, 32'hFF);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0;
    peek("rd_wr_postwrite", A_LED, 32'h33);

    // Channel 0 auto-reload, W1C collision, TL write collision.
    wreg(A_TH0, 32'hFFFF_FFFC);
    wreg(A_TL0, 32'hFFFF_FFFE);
    wreg(A_PR0, 32'h0);
    wreg(A_TC0, 32'h3);
    peek("ch0_start_tl", A_TL0, 32'hFFFF_FFFE);
    tick_n(1);
    peek("ch0_tl_ff", A_TL0, 32'hFFFF_FFFF);
    chk("ch0_no_irq_yet", {31'd0, IRQ}, 32'h0);
    tick_n(1);
    peek("ch0_reload", A_TL0, 32'hFFFF_FFFC);
    peek("ch0_pending", A_STAT, 32'h1);
    chk("ch0_irq", {31'd0, IRQ}, 32'h1);
    chk("ch0_irqvec", {30'd0, irq_vec}, 32'h1);
    tick_n(3);
    peek("ch0_before_ovf2", A_TL0, 32'hFFFF_FFFF);
    tick_n(1);
    peek("ch0_ovf2", A_TL0, 32'hFFFF_FFFC);
    tick_n(3);
    wreg(A_STAT, 32'h1);
    peek("w1c_vs_ovf_pending", A_STAT, 32'h1);
    peek("w1c_vs_ovf_tl", A_TL0, 32'hFFFF_FFFC);
    wreg(A_STAT, 32'h1);
    peek("w1c_quiet", A_STAT, 32'h0);
    chk("w1c_irq_low", {31'd0, IRQ}, 32'h0);
    tick_n(2);
    wreg(A_TL0, 32'h55);
    peek("tlwr_vs_ovf_tl", A_TL0, 32'h55);
    peek("tlwr_vs_ovf_pend", A_STAT, 32'h1);
    wreg(A_TC0, 32'h0);
    wreg(A_STAT, 32'h1);
    peek("ch0_cleared", A_STAT, 32'h0);

    // Channel 1 one-shot with prescaler 3 and IE initially off.
    wreg(A_PR1, 32'h3);
    wreg(A_TH1, 32'h777);
    wreg(A_TL1, 32'hFFFF_FFFF);
    wreg(A_TC1, 32'h5);
    tick_n(3);
    peek("ch1_before_tick", A_TL1, 32'hFFFF_FFFF);
    peek("ch1_not_pending", A_STAT, 32'h0);
    tick_n(1);
    peek("ch1_reload", A_TL1, 32'h777);
    peek("ch1_en_cleared", A_TC1, 32'h4);
    peek("ch1_pending", A_STAT, 32'h2);
    chk("ch1_irqvec_masked", {30'd0, irq_vec}, 32'h0);
    tick_n(5);
    peek("ch1_frozen", A_TL1, 32'h777);
    wreg(A_TC1, 32'h6);
    chk("ch1_ie_irq", {31'd0, IRQ}, 32'h1);
    chk("ch1_ie_irqvec", {30'd0, irq_vec}, 32'h2);

    // Asynchronous reset while channel 0 counts.
    wreg(A_TL0, 32'h10);
    wreg(A_TC0, 32'h1);
    tick_n(2);
    peek("ch0_counting", A_TL0, 32'h12);
    reset = 1'b0; #1;
    peek("async_tl0", A_TL0, 32'h0);
    peek("async_tcon0", A_TC0, 32'h0);
    peek("async_th1", A_TH1, 32'h0);
    peek("async_stat", A_STAT, 32'h0);
    peek("async_led", A_LED, 32'h0);
    chk("async_irq", {31'd0, IRQ}, 32'h0);
    chk("async_irqvec", {30'd0, irq_vec}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick_n(3);
    peek("post_reset_tl0", A_TL0, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      addr  = pick_addr();
      wr    = ($urandom_range(0, 9) < 4);
      rd    = ($urandom_range(0, 7) != 0);
      wdata = pick_data(addr);
      #1;
      chk("rand_rdata", rdata, rd ? mread(addr) : 32'h0);
      exp_vec = '0;
      for (int i = 0; i < N_TIMERS; i++) exp_vec[i] = m_pend[i] & m_ie[i];
      chk("rand_irqvec", {30'd0, irq_vec}, exp_vec);
      chk("rand_irq", {31'd0, IRQ}, {31'd0, |exp_vec});
      @(posedge clk); #1;
    end
    wr = 1'b0; rd = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/peripheral_timer_bank.md
Name: peripheral_timer_bank

Overview:
Memory-mapped peripheral slave on the CPU data bus at base 0x4000_0000. It is the parametrised successor of the single-timer peripheral. It provides N independent reload timers, each with a prescaler, auto-reload or one-shot mode, a per-channel interrupt enable and a sticky W1C pending bit. It also keeps the LED, switch and 7-seg digit registers and drives one combined IRQ to the CPU interrupt logic.

Parameters:
N_TIMERS, 2, number of timer channels (1..8)
LED_W, 8, LED register width (1..32)
SW_W, 8, switch input width (1..32)
DIGI_W, 12, digit register width (1..32)
PRESC_W, 16, prescaler register width (1..32)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rd  input  1  read strobe
wr  input  1  write strobe, sampled at posedge clk
addr  input  32  byte address
wdata  input  32  write data
switch  input  SW_W  board switches (already synchronised)
rdata  output  32  read data
led  output  LED_W  LED register
digi  output  DIGI_W  digit register
irq_vec  output  N_TIMERS  per-channel pending AND irq-enable
IRQ  output  1  OR-reduction of irq_vec

Behaviour:
- Address map, exact word match, no other decode:
  - 0x4000_000C LED (RW)
  - 0x4000_0010 SWITCH (RO)
  - 0x4000_0014 DIGI (RW)
  - 0x4000_0020 IRQ_STAT (bit i = pending i; a write of 1 clears, 0 has no effect)
  - Channel i at 0x4000_0100 + 0x10*i: +0 TH, +4 TL, +8 TCON, +C PRESC
- TCON bits: [0] EN, [1] IE, [2] ONESHOT. Bits [31:3] read 0.
- Reads:
  - rdata is combinational.
  - Unmapped address, or rd=0, gives 0.
  - Narrow registers read zero-extended. Writes to narrow registers take the low bits.
- Reset (reset=0, asynchronous): all TH, TL, TCON, PRESC, prescale counters, pending bits, led and digi go to 0. irq_vec=0, IRQ=0.
- Per channel, per clk:
  - EN=0: prescale counter held at 0, TL frozen.
  - EN=1: prescale counter counts 0..PRESC. A tick occurs in the cycle the counter equals PRESC, and the counter then returns to 0. PRESC=0 gives a tick every cycle, which matches the legacy block.
  - On a tick with TL != 0xFFFF_FFFF: TL increments by 1.
  - On a tick with TL == 0xFFFF_FFFF (overflow):
    - TL loads TH.
    - pending i is set whatever IE is; IE gates only irq_vec.
    - If ONESHOT=1, EN clears. Otherwise the channel keeps running.
- Any write to TCON or PRESC of a channel clears that channel's prescale counter.
- Simultaneous events, same cycle:
  - Bus write to TL and overflow: the written value wins.
  - Bus write to TCON and one-shot EN clear: the written value wins.
  - IRQ_STAT W1C and a new overflow on the same channel: pending stays 1 (set wins).
- irq_vec[i] = pending[i] & IE[i], registered state only; no combinational path from wdata. IRQ is the OR of irq_vec.
- Clearing IE does not clear pending. Re-enabling IE with pending=1 re-asserts IRQ in the same cycle the TCON write takes effect.
- wr and rd may be high together: rdata shows the pre-write value.
- SWITCH writes are ignored.

Test Plan:
1. Reset low mid-count with EN=1, TL=0x10 -> all registers 0 and IRQ=0 immediately (before the next clk); counting does not resume after reset release.
2. Ch0: TH=0xFFFF_FFFC, TL=0xFFFF_FFFE, PRESC=0, TCON=3 -> TL reads ...FF after 1 clk; after 2 clk TL=0xFFFF_FFFC, IRQ_STAT=1, IRQ=1; auto-reload continues, next overflow after 4 more clk.
3. Ch1: PRESC=3, TL=0xFFFF_FFFF, TCON=0b101 -> overflow on the 4th clk; TL=TH, EN reads 0, pending[1]=1, irq_vec[1]=0 (IE=0); then set IE -> IRQ=1.
4. Write IRQ_STAT=0x1 in the same cycle ch0 overflows -> pending[0] remains 1; W1C in a quiet cycle -> 0, IRQ falls.
5. Write TL=0x55 in the overflow cycle -> TL=0x55, pending set.
6. LED write 0xA5, DIGI write 0xFFFF (DIGI_W=12), switch=0x3C -> reads 0xA5, 0xFFF, 0x3C; reads of unmapped 0x4000_0018 and of any address with rd=0 return 0.
